branch_sequencer: RTL and testbench
===================================

Name: branch_sequencer

Overview:
- Owns the fetch PC of the LagartoII monocycle core and issues instruction-fetch requests to instruction memory.
- Sequences the registered branch-address calculator:
  - presents PC and offset operands to it;
  - waits out its one-cycle registered latency;
  - loads the returned target into the PC.
- Generates the front-end flush on taken branches and counts redirects for performance monitoring.

Parameters:
- XLEN, 64, width of PC, offset and target (matches the `WORD width).
- RESET_VEC, 64'h0, first fetch address after reset.
- TRAP_VEC, 64'h100, PC loaded on a misaligned branch target.
- INSTR_BYTES, 4, sequential PC increment.
- CNT_W, 16, width of the redirect counter.

Ports:
- clk_i  in  1  core clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- stall_i  in  1  back-end stall; blocks new fetch requests.
- imem_req_o  out  1  fetch request valid.
- imem_addr_o  out  XLEN  fetch address (equals current PC).
- imem_gnt_i  in  1  memory accepts the request this cycle.
- br_valid_i  in  1  decode presents a resolved branch this cycle.
- br_taken_i  in  1  branch condition true (qualified by br_valid_i).
- br_pc_i  in  XLEN  PC of the branch instruction.
- br_offset_i  in  XLEN  sign-extended offset, unshifted (the calculator applies <<1).
- calc_pc_o  out  XLEN  PC operand to the branch-address calculator.
- calc_offset_o  out  XLEN  offset operand to the calculator.
- calc_target_i  in  XLEN  registered calculator result; valid one clock after operands are stable.
- flush_o  out  1  one-cycle pulse that squashes fetch/decode.
- misalign_o  out  1  one-cycle pulse: target not INSTR_BYTES-aligned.
- busy_o  out  1  high in CALC or LOAD.
- redirect_cnt_o  out  CNT_W  count of taken-branch redirects, saturating.

Behaviour:
- Reset (asynchronous, rst_ni=0):
  - state=BOOT, PC=RESET_VEC;
  - imem_req_o=0, flush_o=0, misalign_o=0, busy_o=0, redirect_cnt_o=0;
  - calc_pc_o=0, calc_offset_o=0.
  - Reset asserted mid-operation aborts any pending redirect immediately.
- State BOOT: single cycle after reset release, then RUN. imem_req_o=0.
- State RUN:
  - imem_req_o = !stall_i; imem_addr_o = PC.
  - If imem_req_o && imem_gnt_i: PC <= PC + INSTR_BYTES, wrapping modulo 2^XLEN.
  - If br_valid_i && br_taken_i:
    - latch br_pc_i to calc_pc_o and br_offset_i to calc_offset_o;
    - flush_o=1 for this cycle;
    - next state CALC.
  - Taken branch together with a grant: the branch wins, PC is not incremented, and the granted fetch is squashed by flush_o.
  - Not-taken branch (br_valid_i && !br_taken_i): no action.
- State CALC:
  - calc operands held stable; imem_req_o=0.
  - The calculator registers the target at this cycle's rising edge; next state LOAD.
- State LOAD:
  - If calc_target_i[$clog2(INSTR_BYTES)-1:0] is nonzero:
    - PC <= TRAP_VEC;
    - misalign_o=1 for one cycle.
  - Otherwise PC <= calc_target_i.
  - redirect_cnt_o increments in both cases, saturating at all-ones.
  - imem_req_o=0; next state RUN.
- Total redirect latency: a taken branch in cycle N produces the first request at the new PC in cycle N+3, provided stall_i=0.
- stall_i:
  - affects only imem_req_o;
  - does not delay the CALC→LOAD→RUN sequence;
  - a PC loaded during stall is held until stall_i drops.
- br_valid_i in CALC or LOAD is ignored, because decode is being flushed. The bench flags it as a protocol error.
- PC is only observable via imem_addr_o. The PC register updates only in RUN (on grant) or in LOAD.

Decomposition:
- Shared package / include (lagartoII_const.vh):
  - sequencer state encoding (BOOT, RUN, CALC, LOAD);
  - RESET_VEC and TRAP_VEC defaults;
  - INSTR_BYTES;
  - `WORD width.
- The existing branch-address calculator stays external and is instantiated beside this block, not inside it.
- One natural sub-module: sat_counter (parametric saturating counter) for redirect_cnt_o.

Test Plan:
- Reset release with gnt held 1, no branches → imem_addr_o sequence 0x0, 0x4, 0x8, 0xC from the cycle after BOOT.
- Taken branch at PC=0x20, br_pc_i=0x1C, offset=0x10 (calculator returns 0x3C) → flush_o pulse in cycle N, no request in N+1/N+2, request at 0x3C in N+3, redirect_cnt_o=1.
- Taken branch coincident with imem_gnt_i=1 at PC=0x40 → PC not incremented to 0x44, flush_o=1, next request goes to the target.
- Calculator returns 0x3E → misalign_o pulse, next request at 0x100, redirect_cnt_o increments.
- stall_i=1 across the whole redirect → imem_req_o stays 0, target still loaded, first request at the target on the cycle after stall_i falls.
- rst_ni pulsed low while in CALC → all outputs at reset values asynchronously, restart at 0x0. Separately, CNT_W=2 with 5 redirects → redirect_cnt_o saturates at 3.

Source files
------------

// File: rtl/branch_sequencer_pkg.sv
// branch_sequencer_pkg
//   Shared constants for the LagartoII fetch/branch sequencer: word width,
//   boot and trap vectors, instruction size and sequencer state encoding.
package branch_sequencer_pkg;

  localparam int              WORD            = 64;
  localparam logic [WORD-1:0] RESET_VEC_DEF   = 64'h0;
  localparam logic [WORD-1:0] TRAP_VEC_DEF    = 64'h100;
  localparam int              INSTR_BYTES_DEF = 4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    CALC = 2'd2,
    LOAD = 2'd3
  } seqState_e;

endpackage

// File: rtl/branch_sequencer_sat_counter.sv
// branch_sequencer_sat_counter
//   Parametric up-counter that sticks at all-ones instead of wrapping.
//   Ports:
//     clk_i   core clock
//     rst_ni  asynchronous active-low reset, clears the count
//     inc     increment request for this cycle
//     count   current count value
module branch_sequencer_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/branch_sequencer.sv
// branch_sequencer
//   Owns the fetch PC, issues fetch requests and sequences the external
//   registered branch-address calculator on taken branches.
//   Ports:
//     clk_i, rst_ni          clock, asynchronous active-low reset
//     stall_i                back-end stall, gates fetch requests only
//     imem_req_o/addr_o      fetch request and address (address = PC)
//     imem_gnt_i             memory accepted the request this cycle
//     br_valid_i/taken_i     resolved branch from decode
//     br_pc_i/br_offset_i    branch PC and unshifted sign-extended offset
//     calc_pc_o/offset_o     held operands to the address calculator
//     calc_target_i          calculator result, one cycle after operands
//     flush_o                squash fetch/decode on a taken branch
//     misalign_o             target not instruction-aligned, trap taken
//     busy_o                 redirect in progress
//     redirect_cnt_o         saturating count of redirects
//
//   state | meaning
//   BOOT  | first cycle after reset, no fetch
//   RUN   | sequential fetch, accepts taken branches
//   CALC  | calculator registers target from held operands
//   LOAD  | target (or trap vector) loaded into PC
module branch_sequencer
  import branch_sequencer_pkg::*;
#(
  parameter int               XLEN        = WORD,
  parameter logic [XLEN-1:0]  RESET_VEC   = RESET_VEC_DEF,
  parameter logic [XLEN-1:0]  TRAP_VEC    = TRAP_VEC_DEF,
  parameter int               INSTR_BYTES = INSTR_BYTES_DEF,
  parameter int               CNT_W       = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              stall_i,
  output logic              imem_req_o,
  output logic [XLEN-1:0]   imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              br_valid_i,
  input  logic              br_taken_i,
  input  logic [XLEN-1:0]   br_pc_i,
  input  logic [XLEN-1:0]   br_offset_i,
  output logic [XLEN-1:0]   calc_pc_o,
  output logic [XLEN-1:0]   calc_offset_o,
  input  logic [XLEN-1:0]   calc_target_i,
  output logic              flush_o,
  output logic              misalign_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  redirect_cnt_o
);

  localparam int ALIGN_W = $clog2(INSTR_BYTES);

  seqState_e       state;
  logic [XLEN-1:0] pc;
  logic            brTaken;
  logic            targetMisaligned;

  // Branches outside RUN arrive while decode is being flushed and are dropped.
  assign brTaken          = (state == RUN) && br_valid_i && br_taken_i;
  assign targetMisaligned = calc_target_i[ALIGN_W-1:0] != '0;

  assign imem_req_o  = (state == RUN) && !stall_i;
  assign imem_addr_o = pc;
  assign flush_o     = brTaken;
  assign misalign_o  = (state == LOAD) && targetMisaligned;
  assign busy_o      = (state == CALC) || (state == LOAD);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= BOOT;
      pc            <= RESET_VEC;
      calc_pc_o     <= '0;
      calc_offset_o <= '0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          // A taken branch overrides a coincident grant; that fetch is squashed.
          if (brTaken) begin
            calc_pc_o     <= br_pc_i;
            calc_offset_o <= br_offset_i;
            state         <= CALC;
          end else if (imem_req_o && imem_gnt_i) begin
            pc <= pc + XLEN'(INSTR_BYTES);
          end
        end
        CALC: state <= LOAD;
        LOAD: begin
          pc    <= targetMisaligned ? TRAP_VEC : calc_target_i;
          state <= RUN;
        end
        default: state <= BOOT;
      endcase
    end
  end

  branch_sequencer_sat_counter #(
    .W (CNT_W)
  ) u_redirectCnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc    (state == LOAD),
    .count  (redirect_cnt_o)
  );

endmodule

// File: tb/tb_branch_sequencer.sv
module tb_branch_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni, stall_i, imem_gnt_i, br_valid_i, br_taken_i;
  logic [63:0] br_pc_i, br_offset_i;

  logic        reqA, flushA, misA, busyA;
  logic [63:0] addrA, calcPcA, calcOffA, calcTgtA;
  logic [15:0] cntA;

  logic        reqB, flushB, misB, busyB;
  logic [63:0] addrB, calcPcB, calcOffB, calcTgtB;
  logic [1:0]  cntB;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  // External registered branch-address calculator, one per instance.
  always @(posedge clk_i) begin
    calcTgtA <= calcPcA + (calcOffA << 1);
    calcTgtB <= calcPcB + (calcOffB << 1);
  end

  branch_sequencer dutA (
    .clk_i(clk_i), .rst_ni(rst_ni), .stall_i(stall_i),
    .imem_req_o(reqA), .imem_addr_o(addrA), .imem_gnt_i(imem_gnt_i),
    .br_valid_i(br_valid_i), .br_taken_i(br_taken_i),
    .br_pc_i(br_pc_i), .br_offset_i(br_offset_i),
    .calc_pc_o(calcPcA), .calc_offset_o(calcOffA), .calc_target_i(calcTgtA),
    .flush_o(flushA), .misalign_o(misA), .busy_o(busyA), .redirect_cnt_o(cntA)
  );

  branch_sequencer #(.CNT_W(2)) dutB (
    .clk_i(clk_i), .rst_ni(rst_ni), .stall_i(stall_i),
    .imem_req_o(reqB), .imem_addr_o(addrB), .imem_gnt_i(imem_gnt_i),
    .br_valid_i(br_valid_i), .br_taken_i(br_taken_i),
    .br_pc_i(br_pc_i), .br_offset_i(br_offset_i),
    .calc_pc_o(calcPcB), .calc_offset_o(calcOffB), .calc_target_i(calcTgtB),
    .flush_o(flushB), .misalign_o(misB), .busy_o(busyB), .redirect_cnt_o(cntB)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: PC, redirect wait count and taken-redirect total.
  int          mBoot, mWait, mCnt;
  logic [63:0] mPc, mTarget, mCalcPc, mCalcOff;

  task automatic modelReset();
    mBoot = 1; mWait = 0; mCnt = 0;
    mPc = 64'h0; mTarget = 64'h0; mCalcPc = 64'h0; mCalcOff = 64'h0;
  endtask

  task automatic modelCheck();
    logic eReq, eFlush, eBusy, eMis;
    eReq = 0; eFlush = 0; eBusy = 0; eMis = 0;
    if (mBoot > 0) begin
      eReq = 0;
    end else if (mWait > 0) begin
      eBusy = 1;
      eMis  = (mWait == 1) && (mTarget[1:0] != 2'b00);
    end else begin
      eReq   = !stall_i;
      eFlush = br_valid_i && br_taken_i;
    end
    check("model_req", 64'(reqA), 64'(eReq));
    check("model_flush", 64'(flushA), 64'(eFlush));
    check("model_busy", 64'(busyA), 64'(eBusy));
    check("model_misalign", 64'(misA), 64'(eMis));
    check("model_addr", addrA, mPc);
    check("model_calc_pc", calcPcA, mCalcPc);
    check("model_calc_off", calcOffA, mCalcOff);
    check("model_cnt", 64'(cntA), 64'(mCnt));
    check("model_cnt_sat", 64'(cntB), 64'((mCnt > 3) ? 3 : mCnt));
    check("model_addr_b", addrB, mPc);
  endtask

  task automatic modelAdvance();
    if (mBoot > 0) begin
      mBoot = 0;
    end else if (mWait == 2) begin
      mWait = 1;
    end else if (mWait == 1) begin
      mPc   = (mTarget[1:0] != 2'b00) ? 64'h100 : mTarget;
      mCnt  = mCnt + 1;
      mWait = 0;
    end else if (br_valid_i && br_taken_i) begin
      mCalcPc  = br_pc_i;
      mCalcOff = br_offset_i;
      mTarget  = br_pc_i + (br_offset_i << 1);
      mWait    = 2;
    end else if (!stall_i && imem_gnt_i) begin
      mPc = mPc + 64'd4;
    end
  endtask

  task automatic drive(input logic st, input logic gn, input logic bv, input logic bt,
                       input logic [63:0] bp, input logic [63:0] bo);
    stall_i = st; imem_gnt_i = gn; br_valid_i = bv; br_taken_i = bt;
    br_pc_i = bp; br_offset_i = bo;
  endtask

  task automatic doCycle(input logic st, input logic gn, input logic bv, input logic bt,
                         input logic [63:0] bp, input logic [63:0] bo);
    drive(st, gn, bv, bt, bp, bo);
    @(negedge clk_i);
    modelCheck();
    modelAdvance();
    @(posedge clk_i);
    #1;
  endtask

  task automatic redirectAt(input logic [63:0] bp, input logic [63:0] bo);
    doCycle(0, 0, 1, 1, bp, bo);
    doCycle(0, 0, 0, 0, 0, 0);
    doCycle(0, 0, 0, 0, 0, 0);
    doCycle(0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    logic        st, gn, bv, bt;
    logic [63:0] bp, bo;
    logic        eReq, eFlush, eBusy, eMis;
    logic [63:0] eAddr;
    int          eCnt;
  } vec_t;

  vec_t vecs[17];

  initial begin
    //          st gn bv bt bp      bo     req fl bs ms addr    cnt
    vecs[0]  = '{0, 1, 0, 0, 64'h0,  64'h0, 0, 0, 0, 0, 64'h0,   0};
    vecs[1]  = '{0, 1, 0, 0, 64'h0,  64'h0, 1, 0, 0, 0, 64'h0,   0};
    vecs[2]  = '{0, 1, 0, 0, 64'h0,  64'h0, 1, 0, 0, 0, 64'h4,   0};
    vecs[3]  = '{0, 1, 0, 0, 64'h0,  64'h0, 1, 0, 0, 0, 64'h8,   0};
    vecs[4]  = '{0, 1, 0, 0, 64'h0,  64'h0, 1, 0, 0, 0, 64'hC,   0};
    vecs[5]  = '{0, 1, 1, 0, 64'h8,  64'h4, 1, 0, 0, 0, 64'h10,  0};
    vecs[6]  = '{0, 1, 0, 0, 64'h0,  64'h0, 1, 0, 0, 0, 64'h14,  0};
    vecs[7]  = '{0, 1, 0, 0, 64'h0,  64'h0, 1, 0, 0, 0, 64'h18,  0};
    vecs[8]  = '{0, 1, 0, 0, 64'h0,  64'h0, 1, 0, 0, 0, 64'h1C,  0};
    vecs[9]  = '{0, 0, 1, 1, 64'h1C, 64'h10, 1, 1, 0, 0, 64'h20, 0};
    vecs[10] = '{0, 1, 0, 0, 64'h0,  64'h0, 0, 0, 1, 0, 64'h20,  0};
    vecs[11] = '{0, 1, 0, 0, 64'h0,  64'h0, 0, 0, 1, 0, 64'h20,  0};
    vecs[12] = '{0, 1, 0, 0, 64'h0,  64'h0, 1, 0, 0, 0, 64'h3C,  1};
    vecs[13] = '{0, 1, 1, 1, 64'h30, 64'h7, 1, 1, 0, 0, 64'h40,  1};
    vecs[14] = '{0, 1, 0, 0, 64'h0,  64'h0, 0, 0, 1, 0, 64'h40,  1};
    vecs[15] = '{0, 1, 0, 0, 64'h0,  64'h0, 0, 0, 1, 1, 64'h40,  1};
    vecs[16] = '{0, 0, 0, 0, 64'h0,  64'h0, 1, 0, 0, 0, 64'h100, 2};

    rst_ni = 1'b0;
    drive(0, 1, 0, 0, 0, 0);
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_req", 64'(reqA), 64'h0);
    check("rst_flush", 64'(flushA), 64'h0);
    check("rst_busy", 64'(busyA), 64'h0);
    check("rst_misalign", 64'(misA), 64'h0);
    check("rst_addr", addrA, 64'h0);
    check("rst_calc_pc", calcPcA, 64'h0);
    check("rst_calc_off", calcOffA, 64'h0);
    check("rst_cnt", 64'(cntA), 64'h0);
    rst_ni = 1'b1;
    modelReset();

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].st, vecs[i].gn, vecs[i].bv, vecs[i].bt, vecs[i].bp, vecs[i].bo);
      @(negedge clk_i);
      check($sformatf("vec%0d_req", i), 64'(reqA), 64'(vecs[i].eReq));
      check($sformatf("vec%0d_flush", i), 64'(flushA), 64'(vecs[i].eFlush));
      check($sformatf("vec%0d_busy", i), 64'(busyA), 64'(vecs[i].eBusy));
      check($sformatf("vec%0d_misalign", i), 64'(misA), 64'(vecs[i].eMis));
      check($sformatf("vec%0d_addr", i), addrA, vecs[i].eAddr);
      check($sformatf("vec%0d_cnt", i), 64'(cntA), 64'(vecs[i].eCnt));
      modelCheck();
      modelAdvance();
      @(posedge clk_i);
      #1;
    end

    // Reset asserted while the calculator is working aborts the redirect.
    doCycle(0, 0, 1, 1, 64'h200, 64'h8);
    drive(0, 1, 0, 0, 0, 0);
    #2;
    check("calc_busy_before_rst", 64'(busyA), 64'h1);
    check("calc_pc_before_rst", calcPcA, 64'h200);
    rst_ni = 1'b0;
    #1;
    check("async_rst_busy", 64'(busyA), 64'h0);
    check("async_rst_req", 64'(reqA), 64'h0);
    check("async_rst_addr", addrA, 64'h0);
    check("async_rst_calc_pc", calcPcA, 64'h0);
    check("async_rst_calc_off", calcOffA, 64'h0);
    check("async_rst_cnt", 64'(cntA), 64'h0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    modelReset();
    doCycle(0, 1, 0, 0, 0, 0);
    doCycle(0, 1, 0, 0, 0, 0);
    doCycle(0, 1, 0, 0, 0, 0);
    check("restart_addr", addrA, 64'h8);

    // Stall held across the whole redirect: target loaded but not requested.
    doCycle(1, 1, 1, 1, 64'h80, 64'h20);
    doCycle(1, 1, 0, 0, 0, 0);
    doCycle(1, 1, 0, 0, 0, 0);
    doCycle(1, 1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    #1;
    check("stall_held_req", 64'(reqA), 64'h0);
    check("stall_held_addr", addrA, 64'hC0);
    doCycle(1, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    #1;
    check("unstall_req", 64'(reqA), 64'h1);
    check("unstall_addr", addrA, 64'hC0);
    doCycle(0, 1, 0, 0, 0, 0);

    // Four more redirects: five total, 2-bit counter pinned at 3.
    redirectAt(64'h400, 64'h10);
    redirectAt(64'h500, 64'h3);
    redirectAt(64'h600, 64'h20);
    redirectAt(64'h700, 64'h40);
    check("cnt16_after5", 64'(cntA), 64'd5);
    check("cnt2_saturated", 64'(cntB), 64'd3);

    for (int i = 0; i < 400; i++) begin
      logic        st, gn, bv, bt;
      logic [11:0] o12;
      logic [63:0] bp, bo;
      st  = ($urandom_range(3) == 0);
      gn  = ($urandom_range(9) < 7);
      bv  = (mBoot == 0) && (mWait == 0) && ($urandom_range(6) == 0);
      bt  = bv && $urandom_range(1) == 1;
      o12 = 12'($urandom);
      bo  = {{52{o12[11]}}, o12};
      bp  = {$urandom, $urandom};
      doCycle(st, gn, bv, bt, bp, bo);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
